// File: rtl/knn_data_feeder_if.sv
`timescale 1ns/1ps
// knn_data_feeder_if: loader, query and serving handshake bundle of the KNN
// training-sample feeder. The master side is the host loader plus the KNN
// datapath; the slave side is the feeder itself.
interface knn_data_feeder_if #(
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int W            = 8,
  parameter int MAX_ELEMENTS = 16,
  parameter int TYPE_W       = 4
) ();
  localparam int PW = W * M * N;
  localparam int CW = $clog2(MAX_ELEMENTS + 1);

  logic              clear;
  logic              load_valid;
  logic              load_ready;
  logic [PW-1:0]     load_data;
  logic [TYPE_W-1:0] load_type;
  logic              load_last;
  logic              input_valid;
  logic [PW-1:0]     input_pixels;
  logic              start;
  logic              data_request;
  logic              read_done;
  logic [PW-1:0]     training_data;
  logic [TYPE_W-1:0] training_data_type;
  logic [PW-1:0]     input_data;
  logic [CW-1:0]     sample_count;
  logic              pass_done;

  modport master (
    output clear, load_valid, load_data, load_type, load_last,
    output input_valid, input_pixels, start, data_request,
    input  load_ready, read_done, training_data, training_data_type,
    input  input_data, sample_count, pass_done
  );

  modport slave (
    input  clear, load_valid, load_data, load_type, load_last,
    input  input_valid, input_pixels, start, data_request,
    output load_ready, read_done, training_data, training_data_type,
    output input_data, sample_count, pass_done
  );
endinterface

// File: rtl/knn_data_feeder.sv
`timescale 1ns/1ps
// knn_data_feeder: buffers up to MAX_ELEMENTS labelled training images and one
// query image, then serves the stored samples one per data_request to the KNN
// distance datapath, pulsing read_done per sample and pass_done on the last.
module knn_data_feeder #(
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int W            = 8,
  parameter int MAX_ELEMENTS = 16,
  parameter int TYPE_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  knn_data_feeder_if.slave bus
);
  localparam int PW = W * M * N;
  localparam int CW = $clog2(MAX_ELEMENTS + 1);
  localparam int AW = (MAX_ELEMENTS > 1) ? $clog2(MAX_ELEMENTS) : 1;
  localparam int DW = PW + TYPE_W;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ELEMENTS);

  typedef enum logic [2:0] {S_IDLE, S_LOADED, S_WAIT, S_FETCH, S_HOLD} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DW-1:0]     r_mem [MAX_ELEMENTS];
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_rd_ptr;
  logic [CW-1:0]     w_rd_ptr_inc;
  logic              w_load_ready;
  logic              w_accept;
  logic              w_latch_input;
  logic              r_read_done;
  logic              r_pass_done;
  logic [PW-1:0]     r_training_data;
  logic [TYPE_W-1:0] r_training_type;
  logic [PW-1:0]     r_input_data;

  // Beats are only taken while loading with room left; clear drops a beat.
  assign w_load_ready  = (r_state == S_IDLE) && (r_count < MAX_CNT);
  assign w_accept      = bus.load_valid && w_load_ready && !bus.clear;
  // The query may only change between passes so a pass sees one query.
  assign w_latch_input = bus.input_valid && !bus.clear &&
                         ((r_state == S_IDLE) || (r_state == S_LOADED));
  assign w_rd_ptr_inc  = r_rd_ptr + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; clear overrides everything and aborts any pass.
  always_comb begin
    w_state_next = r_state;
    if (bus.clear) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_accept && (bus.load_last || (r_count == MAX_CNT - 1'b1)))
                    w_state_next = S_LOADED;
        S_LOADED: if (bus.start) w_state_next = S_WAIT;
        S_WAIT:   if (bus.data_request) w_state_next = S_FETCH;
        S_FETCH:  w_state_next = S_HOLD;
        S_HOLD:   w_state_next = (r_rd_ptr == r_count) ? S_LOADED : S_WAIT;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // Sample buffer write port; contents are deliberately not reset or cleared.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_count[AW-1:0]] <= {bus.load_data, bus.load_type};
  end

  // Counters, fetch register, handshake pulses and query register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count         <= '0;
      r_rd_ptr        <= '0;
      r_read_done     <= 1'b0;
      r_pass_done     <= 1'b0;
      r_training_data <= '0;
      r_training_type <= '0;
      r_input_data    <= '0;
    end else begin
      r_read_done <= 1'b0;
      r_pass_done <= 1'b0;
      if (w_latch_input) r_input_data <= bus.input_pixels;
      if (bus.clear) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_accept) r_count <= r_count + 1'b1;
        if ((r_state == S_LOADED) && bus.start) r_rd_ptr <= '0;
        if (r_state == S_FETCH) begin
          {r_training_data, r_training_type} <= r_mem[r_rd_ptr[AW-1:0]];
          r_read_done <= 1'b1;
          // pass_done rides on the read_done of the final stored sample.
          r_pass_done <= (w_rd_ptr_inc == r_count);
          r_rd_ptr    <= w_rd_ptr_inc;
        end
      end
    end
  end

  assign bus.load_ready         = w_load_ready;
  assign bus.read_done          = r_read_done;
  assign bus.pass_done          = r_pass_done;
  assign bus.training_data      = r_training_data;
  assign bus.training_data_type = r_training_type;
  assign bus.input_data         = r_input_data;
  assign bus.sample_count       = r_count;
endmodule

// File: doc/knn_data_feeder.md
# knn_data_feeder

Training-sample source for the KNN system: buffers up to MAX_ELEMENTS labelled training images plus one query image, then serves them one sample per request over the `data_request` / `read_done` handshake that the KNN distance datapath consumes. It sits between the host/testbench loader and `knn_system`. Its outputs connect directly to `read_done`, `training_data`, `training_data_type` and `input_data`.

## Interface
- M, 4, image rows
- N, 4, image columns
- W, 8, bits per pixel
- MAX_ELEMENTS, 16, sample buffer depth (≥1); CW = $clog2(MAX_ELEMENTS+1)
- TYPE_W, 4, label width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush: count←0, state←IDLE
- load_valid  in  1  load beat valid
- load_ready  out  1  buffer accepts a beat
- load_data  in  W*M*N  training image
- load_type  in  TYPE_W  training label
- load_last  in  1  final beat of the load
- input_valid  in  1  latch query image
- input_pixels  in  W*M*N  query image
- start  in  1  begin serving pass
- data_request  in  1  consumer asks for next sample
- read_done  out  1  one-cycle pulse: sample outputs valid
- training_data  out  W*M*N  served image
- training_data_type  out  TYPE_W  served label
- input_data  out  W*M*N  registered query image
- sample_count  out  CW  stored samples
- pass_done  out  1  one-cycle pulse with final read_done of a pass

## Operation
- States: IDLE (loading), LOADED, WAIT, FETCH, HOLD.
- IDLE: load_ready = (sample_count < MAX_ELEMENTS), combinational. A beat is accepted on load_valid && load_ready: mem[sample_count]←{load_data,load_type}, sample_count+1. An accepted beat with load_last, or one that makes sample_count reach MAX_ELEMENTS, moves to LOADED. load_valid while load_ready=0 is dropped.
- LOADED: load_ready=0. start → rd_ptr←0, WAIT. start in IDLE is ignored. LOADED always has sample_count ≥ 1.
- WAIT: data_request=1 → FETCH.
- FETCH: register mem[rd_ptr] onto training_data/training_data_type, set read_done←1, rd_ptr+1, → HOLD.
- HOLD: read_done deasserts at the next edge. If rd_ptr == sample_count, go to LOADED with pass_done high together with the read_done cycle. Otherwise go to WAIT.
- data_request is ignored outside WAIT, including in HOLD. A consumer holding it high therefore receives one sample every 3 cycles.
- input_valid in IDLE or LOADED registers input_pixels→input_data. It is ignored in WAIT/FETCH/HOLD, so the query stays stable through a pass.
- training_data, training_data_type and input_data hold their value until overwritten.
- clear has priority over every other input in any state. A simultaneous load beat is dropped, and a pass in progress is aborted without pass_done. Memory contents are not erased; input_data is kept.
- Buffer contents survive a pass; start from LOADED replays the same samples.

## Timing
- Reset (async): state IDLE, sample_count 0, rd_ptr 0, read_done 0, pass_done 0, training_data 0, training_data_type 0, input_data 0, load_ready 1.
- Request latency: data_request sampled high at edge e0 in WAIT. read_done and data are valid in the cycle after edge e1 (FETCH). read_done is low again after e2.
- Load throughput: 1 beat/cycle. After the last beat's edge, LOADED; start is accepted on the following edge.
- rst asserted mid-pass: outputs drop immediately to reset values.

## Test plan
- Load 3 beats (labels 1,2,3, last on the third), start, hold data_request=1 → read_done pulses every 3 cycles with labels 1,2,3. pass_done coincides with label 3. State returns to LOADED and sample_count=3.
- Load 16 beats with no load_last (MAX_ELEMENTS=16) → load_ready=0 after the 16th. A 17th load_valid is dropped and sample_count=16.
- Single request pulse in WAIT → read_done exactly 2 edges later, lasting 1 cycle. A request pulse presented during HOLD produces no extra read_done.
- input_valid with pattern 0xA5.. in LOADED → input_data updates. input_valid with 0x3C.. during WAIT → input_data stays 0xA5..
- clear asserted after the 2nd read_done of a 4-sample pass, together with load_valid → IDLE, sample_count 0, no pass_done, beat not stored.
- rst pulse mid-FETCH → read_done, training_data and sample_count are 0 asynchronously, and load_ready=1.
